// File: rtl/upg_word_loader.sv
// UPG write-port loader: frames a UART byte stream into 32-bit little-endian ROM writes.
// Optional trailing XOR checksum byte is enabled by defining UPG_CHECKSUM_EN.
module upg_word_loader #(
    parameter int DEPTH          = 16384,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        upg_wen_o,
    output logic [13:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o,
    output logic        upg_busy_o
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     DEPTH_L  = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef UPG_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [15:0]   n_q, n_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   asm_q, asm_d;
    logic [31:0]   dat_q, dat_d;
    logic [13:0]   adr_q, adr_d;
    logic          wen_q, wen_d;
    logic [TW-1:0] tmo_q, tmo_d;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]    xor_q, xor_d;
`endif

    logic [15:0] len_w;
    logic        words_left;
    logic        in_frame;

    assign len_w      = {rx_data_i, len_lo_q};
    assign words_left = (word_cnt_q != n_q);

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        dat_d      = dat_q;
        adr_d      = adr_q;
        wen_d      = 1'b0;
        tmo_d      = '0;
        in_frame   = 1'b0;
`ifdef UPG_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            S_LEN0: begin
                if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                in_frame = 1'b1;
                if (rx_valid_i) begin
                    n_d        = len_w;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    if (len_w == 16'd0)
                        state_d = S_DONE;
                    else if ({1'b0, len_w} > DEPTH_L)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_frame = 1'b1;
                // Bytes shift in from the top so the first byte ends up in [7:0].
                if (rx_valid_i && words_left) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef UPG_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data_i;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        dat_d      = {rx_data_i, asm_q};
                        adr_d      = word_cnt_q[13:0];
                        wen_d      = 1'b1;
                        word_cnt_d = word_cnt_q + 16'd1;
`ifdef UPG_CHECKSUM_EN
                        if (word_cnt_q + 16'd1 == n_q)
                            state_d = S_CSUM;
`endif
                    end else begin
                        asm_d = {rx_data_i, asm_q[23:8]};
                    end
                end
`ifndef UPG_CHECKSUM_EN
                // Leave one cycle after the last byte so done never overlaps the strobe.
                if (!words_left)
                    state_d = S_DONE;
`endif
            end
`ifdef UPG_CHECKSUM_EN
            S_CSUM: begin
                in_frame = 1'b1;
                if (rx_valid_i)
                    state_d = (rx_data_i == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: ;
        endcase

        if (in_frame) begin
            if (rx_valid_i)
                tmo_d = '0;
            else if (tmo_q == TMO_LAST && state_d == state_q)
                state_d = S_ERR;
            else
                tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            state_q    <= S_LEN0;
            len_lo_q   <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            dat_q      <= '0;
            adr_q      <= '0;
            wen_q      <= 1'b0;
            tmo_q      <= '0;
`ifdef UPG_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            dat_q      <= dat_d;
            adr_q      <= adr_d;
            wen_q      <= wen_d;
            tmo_q      <= tmo_d;
`ifdef UPG_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = (state_q == S_DONE);
    assign upg_err_o  = (state_q == S_ERR);
    assign upg_busy_o = in_frame;

endmodule

// File: doc/upg_word_loader.md
Name: upg_word_loader

Overview:
- Writer side of the UART-programmer (UPG) write port on the instruction ROM.
- Takes a byte stream from the UART receiver, frames it and assembles 32-bit little-endian words.
- Issues one-cycle write strobes with a word address and data, then raises the done flag that hands the ROM back to the CPU clock.
- Detects oversize frames, stalled links and (optionally) checksum errors.

Parameters:
- DEPTH, 16384, number of 32-bit words in the target ROM; the largest legal word count.
- TIMEOUT_CYCLES, 10000000, idle cycles allowed between bytes inside a frame (1 s at 10 MHz); minimum 1.

Ports:
- upg_clk_i  input  1  UPG clock (10 MHz); all logic is on its rising edge.
- upg_rst_i  input  1  synchronous reset, active-high.
- rx_data_i  input  8  received byte.
- rx_valid_i  input  1  one-cycle strobe; rx_data_i is valid while it is high.
- upg_wen_o  output  1  one-cycle ROM write strobe.
- upg_adr_o  output  14  word address (word index, not byte address).
- upg_dat_o  output  32  write data.
- upg_done_o  output  1  programming finished; sticky.
- upg_err_o  output  1  frame error; sticky.
- upg_busy_o  output  1  frame in progress.

Behaviour:
- Clock and reset: one clock, upg_clk_i; reset upg_rst_i is synchronous and active-high.
- Reset values: all outputs 0; state S_LEN0; word counter, byte counter and timeout counter 0.
- Reset mid-frame: discards the partial word and the frame. The next frame starts at address 0.
- Frame format, in order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N×4 payload bytes; the first byte of each word goes to bits [7:0].
  - With CHECKSUM_EN only: one trailing checksum byte.
- States:
  - S_LEN0: idle. On rx_valid, latch LEN_LO and go to S_LEN1.
  - S_LEN1: on rx_valid, latch LEN_HI and evaluate N:
    - N=0: go to S_DONE.
    - N>DEPTH: go to S_ERR.
    - otherwise: go to S_DATA.
  - S_DATA: each rx_valid shifts one byte into a word assembly register; a 2-bit byte counter tracks the position.
    - On byte 3, copy the assembly register to upg_dat_o. Next cycle: upg_wen_o=1 for exactly 1 cycle, upg_adr_o = current word index.
    - Word index increments after the strobe.
    - After word N-1, go to S_DONE, or to S_CSUM under CHECKSUM_EN.
  - S_CSUM: defined under Optional Feature.
  - S_DONE: upg_done_o=1, first asserted the cycle after the final upg_wen_o pulse, so done never coincides with a write. For N=0, done is asserted the cycle after LEN_HI.
  - S_ERR: upg_err_o=1; upg_done_o stays 0.
  - S_DONE and S_ERR are terminal until reset; rx_valid_i is ignored there.
- Output holding: upg_adr_o and upg_dat_o hold their last values between strobes.
- Back-to-back bytes:
  - The assembly register is separate from upg_dat_o, so a byte arriving in the strobe cycle is accepted without corrupting the write.
  - Must sustain rx_valid_i high on every cycle.
- upg_busy_o: 1 in S_LEN1, S_DATA and S_CSUM; 0 otherwise.
- Timeout:
  - In S_LEN1, S_DATA and S_CSUM, a counter clears on every rx_valid_i and increments otherwise.
  - Reaching TIMEOUT_CYCLES goes to S_ERR. A pending strobe in that same cycle still completes.
  - S_LEN0 never times out.
- Address width: N ≤ DEPTH is guaranteed by the length check, so the address never wraps.

Optional Feature:
- Macro: UPG_CHECKSUM_EN.
- Defined:
  - Running XOR over all payload bytes (length bytes excluded).
  - After the last word, S_CSUM waits for one byte. Match: S_DONE. Mismatch: S_ERR.
  - Words are already written on mismatch; err signals the CPU must not start.
- Undefined: no S_CSUM state and no XOR register; done follows the last write directly.

Test Plan:
- Two-word frame: bytes 02 00 78 56 34 12 EF BE AD DE → wen pulses at adr 0 with dat 0x12345678, then adr 1 with dat 0xDEADBEEF. Done rises 1 cycle after the 2nd pulse; err=0; busy falls with done.
- Empty frame: 00 00 → no wen; done=1 the cycle after the 2nd byte.
- Oversize frame: 01 40 (N=16385) → err=1, no wen; later bytes ignored; done stays 0.
- Timeout (TIMEOUT_CYCLES=100): 01 00 AA then idle → err=1 exactly 100 cycles after the AA strobe; no wen.
- Reset mid-frame, back-to-back: send 01 00 11 22 33, pulse reset 1 cycle → all outputs 0. Then send 01 00 44 33 22 11 with rx_valid high every cycle → single wen at adr 0, dat 0x11223344.
- UPG_CHECKSUM_EN: 01 00 11 22 33 44 44 → done. Same frame with checksum 45 → err; the write at adr 0 still occurred.
